// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the dmem port arbiter: request record, arbiter state, idle request constant.
package data_types;

  typedef logic [31:0] word32_t;

  typedef struct packed {
    logic    write;
    word32_t addr;
    word32_t data;
  } dmem_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } dmem_arb_state_e;

  localparam dmem_req_t DMEM_REQ_IDLE = '0;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Round-robin two-requester arbiter for the single data-memory port, one transaction in flight.
// Optional busy timeout/abort enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_port_arbiter
  import data_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    req0_valid_i,
  input  logic    req0_write_i,
  input  word32_t req0_addr_i,
  input  word32_t req0_data_i,
  output logic    req0_ready_o,
  output logic    req0_done_o,
  output word32_t req0_rd_data_o,
  output logic    req0_err_o,
  input  logic    req1_valid_i,
  input  logic    req1_write_i,
  input  word32_t req1_addr_i,
  input  word32_t req1_data_i,
  output logic    req1_ready_o,
  output logic    req1_done_o,
  output word32_t req1_rd_data_o,
  output logic    req1_err_o,
  input  word32_t dmem_rd_data_i,
  input  logic    dmem_done_i,
  output logic    dmem_read_o,
  output logic    dmem_write_o,
  output word32_t dmem_addr_o,
  output word32_t dmem_data_o
);

  dmem_arb_state_e state_q, state_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  dmem_req_t       req_q, req_d;
  logic [1:0]      done_q, done_d;
  word32_t [1:0]   rd_data_q, rd_data_d;

  logic [1:0] vld;
  logic       win;
  logic       idle;
  dmem_req_t  sel_req;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          limit;
  // cnt_q holds the number of busy cycles already completed, so the limit
  // cycle is the TIMEOUT_CYCLES-th busy cycle.
  assign limit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  assign vld  = {req1_valid_i, req0_valid_i};
  assign idle = (state_q == ARB_IDLE);
  assign win  = (vld[0] & vld[1]) ? prio_q : vld[1];

  assign sel_req = win ? '{write: req1_write_i, addr: req1_addr_i, data: req1_data_i}
                       : '{write: req0_write_i, addr: req0_addr_i, data: req0_data_i};

  assign req0_ready_o = idle & ~reset_i & vld[0] & ~win;
  assign req1_ready_o = idle & ~reset_i & vld[1] &  win;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    req_d     = req_q;
    done_d    = '0;
    rd_data_d = rd_data_q;
`ifdef DMEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|vld) begin
          req_d   = sel_req;
          owner_d = win;
          prio_d  = ~win;
          state_d = ARB_BUSY;
`ifdef DMEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_BUSY: begin
        if (dmem_done_i) begin
          state_d         = ARB_IDLE;
          done_d[owner_q] = 1'b1;
          if (!req_q.write) rd_data_d[owner_q] = dmem_rd_data_i;
`ifdef DMEM_ARB_TIMEOUT_EN
        end else if (limit) begin
          state_d         = ARB_IDLE;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ARB_IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      req_q     <= DMEM_REQ_IDLE;
      done_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign req0_err_o = err_q[0];
  assign req1_err_o = err_q[1];
`else
  assign req0_err_o = 1'b0;
  assign req1_err_o = 1'b0;
`endif

  assign dmem_read_o    = (state_q == ARB_BUSY) & ~req_q.write;
  assign dmem_write_o   = (state_q == ARB_BUSY) &  req_q.write;
  assign dmem_addr_o    = req_q.addr;
  assign dmem_data_o    = req_q.data;
  assign req0_done_o    = done_q[0];
  assign req1_done_o    = done_q[1];
  assign req0_rd_data_o = rd_data_q[0];
  assign req1_rd_data_o = rd_data_q[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_dmem_port_arbiter;

  localparam int TO = 4;
`ifdef DMEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int SL    = 3;
`else
  localparam bit TO_EN = 1'b0;
  localparam int SL    = 5;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req0_valid_i, req0_write_i, req1_valid_i, req1_write_i;
  logic [31:0] req0_addr_i, req0_data_i, req1_addr_i, req1_data_i;
  logic        req0_ready_o, req0_done_o, req0_err_o;
  logic        req1_ready_o, req1_done_o, req1_err_o;
  logic [31:0] req0_rd_data_o, req1_rd_data_o;
  logic [31:0] dmem_rd_data_i, dmem_addr_o, dmem_data_o;
  logic        dmem_done_i, dmem_read_o, dmem_write_o;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
    .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o), .req0_done_o(req0_done_o),
    .req0_rd_data_o(req0_rd_data_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
    .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o), .req1_done_o(req1_done_o),
    .req1_rd_data_o(req1_rd_data_o), .req1_err_o(req1_err_o),
    .dmem_rd_data_i(dmem_rd_data_i), .dmem_done_i(dmem_done_i),
    .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
    .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o)
  );

  int total = 0;
  int bad   = 0;
  int glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction record, busy age,
  // per-port completion flags and last load data.
  bit          m_busy, m_wr;
  int          m_owner, m_prio, m_age;
  logic [31:0] m_addr, m_data;
  logic [31:0] m_rd[2];
  bit          m_done[2], m_err[2];

  function automatic int pick(input bit v0, input bit v1, input int prio);
    if (v0 && v1) return prio;
    return v0 ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_owner = 0; m_prio = 0; m_age = 0;
    m_addr = 0; m_data = 0;
    for (int k = 0; k < 2; k++) begin m_rd[k] = 0; m_done[k] = 0; m_err[k] = 0; end
  endtask

  always @(negedge clk) begin
    int w;
    bit any;
    if (reset_i) model_reset();
    any = !reset_i && !m_busy && (req0_valid_i || req1_valid_i);
    w   = pick(req0_valid_i, req1_valid_i, m_prio);
    chk("m_ready0", req0_ready_o, any && w == 0);
    chk("m_ready1", req1_ready_o, any && w == 1);
    chk("m_read", dmem_read_o, m_busy && !m_wr);
    chk("m_write", dmem_write_o, m_busy && m_wr);
    chk("m_addr", dmem_addr_o, m_addr);
    chk("m_data", dmem_data_o, m_data);
    chk("m_done0", req0_done_o, m_done[0]);
    chk("m_done1", req1_done_o, m_done[1]);
    chk("m_err0", req0_err_o, m_err[0]);
    chk("m_err1", req1_err_o, m_err[1]);
    chk("m_rd0", req0_rd_data_o, m_rd[0]);
    chk("m_rd1", req1_rd_data_o, m_rd[1]);
    if (req0_valid_i && req0_ready_o) glog.push_back(0);
    if (req1_valid_i && req1_ready_o) glog.push_back(1);
    if (!reset_i) begin
      m_done[0] = 0; m_done[1] = 0; m_err[0] = 0; m_err[1] = 0;
      if (m_busy) begin
        m_age++;
        if (dmem_done_i) begin
          m_busy = 0; m_done[m_owner] = 1;
          if (!m_wr) m_rd[m_owner] = dmem_rd_data_i;
        end else if (TO_EN && m_age == TO) begin
          m_busy = 0; m_done[m_owner] = 1; m_err[m_owner] = 1;
        end
      end else if (any) begin
        m_busy = 1; m_owner = w; m_prio = 1 - w; m_age = 0;
        m_wr   = (w == 0) ? req0_write_i : req1_write_i;
        m_addr = (w == 0) ? req0_addr_i : req1_addr_i;
        m_data = (w == 0) ? req0_data_i : req1_data_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rcnt, ecnt;
    reset_i = 1; req0_valid_i = 0; req0_write_i = 0; req0_addr_i = 0; req0_data_i = 0;
    req1_valid_i = 0; req1_write_i = 0; req1_addr_i = 0; req1_data_i = 0;
    dmem_rd_data_i = 0; dmem_done_i = 0;
    repeat (3) tick();
    chk("rst_read", dmem_read_o, 0);
    chk("rst_write", dmem_write_o, 0);
    chk("rst_rd0", req0_rd_data_o, 0);
    chk("rst_done0", req0_done_o, 0);
    reset_i = 0;
    tick();

    // store from req0, completion SL cycles after strobe
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 2; req0_data_i = 0;
    #1 chk("st_ready", req0_ready_o, 1);
    tick();
    req0_valid_i = 0;
    for (int i = 1; i <= SL; i++) begin
      dmem_done_i = (i == SL);
      #1;
      chk("st_write", dmem_write_o, 1);
      chk("st_addr", dmem_addr_o, 2);
      tick();
    end
    dmem_done_i = 0;
    chk("st_done", req0_done_o, 1);
    chk("st_err", req0_err_o, 0);
    chk("st_wr_low", dmem_write_o, 0);
    tick();
    chk("st_done_pulse", req0_done_o, 0);

    // load from req0, data 500
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 2;
    tick();
    req0_valid_i = 0;
    chk("ld_read", dmem_read_o, 1);
    tick();
    chk("ld_read2", dmem_read_o, 1);
    dmem_done_i = 1; dmem_rd_data_i = 500;
    tick();
    dmem_done_i = 0; dmem_rd_data_i = 0;
    chk("ld_done", req0_done_o, 1);
    chk("ld_rd", req0_rd_data_o, 500);
    tick(); tick();
    chk("ld_rd_hold", req0_rd_data_o, 500);
    chk("ld_done_low", req0_done_o, 0);

    // fresh reset, then both requesters continuously valid
    reset_i = 1;
    tick();
    reset_i = 0;
    chk("rst_rd0_clr", req0_rd_data_o, 0);
    glog.delete();
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 10;
    req1_valid_i = 1; req1_write_i = 1; req1_addr_i = 20; req1_data_i = 77;
    dmem_rd_data_i = 32'h1234;
    for (int i = 0; i < 10; i++) begin
      dmem_done_i = dmem_read_o | dmem_write_o;
      #1;
      if (i == 0) chk("rr_first", req0_ready_o, 1);
      if (i == 2) begin
        chk("rr_done0", req0_done_o, 1);
        chk("rr_ready1", req1_ready_o, 1);
        chk("rr_rd0", req0_rd_data_o, 32'h1234);
      end
      tick();
    end
    req0_valid_i = 0; req1_valid_i = 0; dmem_done_i = 0;
    tick(); tick();
    chk("rr_count", glog.size(), 5);
    if (glog.size() >= 4) begin
      chk("rr_g0", glog[0], 0);
      chk("rr_g1", glog[1], 1);
      chk("rr_g2", glog[2], 0);
      chk("rr_g3", glog[3], 1);
    end

    // reset in the middle of a req1 store
    req1_valid_i = 1; req1_write_i = 1; req1_addr_i = 30; req1_data_i = 3;
    tick();
    req1_valid_i = 0;
    tick();
    chk("mid_write", dmem_write_o, 1);
    reset_i = 1;
    #1;
    chk("mid_rst_write", dmem_write_o, 0);
    chk("mid_rst_read", dmem_read_o, 0);
    tick();
    reset_i = 0; dmem_done_i = 1;
    tick();
    dmem_done_i = 0;
    chk("mid_done0", req0_done_o, 0);
    chk("mid_done1", req1_done_o, 0);
    tick();
    chk("mid_done1b", req1_done_o, 0);
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 0;
    #1 chk("mid_idle_ready", req0_ready_o, 1);
    tick();
    req0_valid_i = 0; dmem_done_i = 1; dmem_rd_data_i = 5;
    tick();
    dmem_done_i = 0;
    tick();

    // no completion: abort with the timeout build, wait forever without
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 40;
    tick();
    req0_valid_i = 0;
    rcnt = 0; ecnt = 0;
    for (int i = 0; i < 6; i++) begin
      rcnt += int'(dmem_read_o);
      if (req0_done_o && req0_err_o) ecnt++;
      tick();
    end
    if (TO_EN) begin
      chk("to_strobe_cycles", rcnt, TO);
      chk("to_err_pulse", ecnt, 1);
      dmem_done_i = 1; dmem_rd_data_i = 32'hDEAD;
      tick();
      dmem_done_i = 0;
      chk("to_late_done", req0_done_o, 0);
      chk("to_rd_keep", req0_rd_data_o, 5);
    end else begin
      chk("nto_strobe_cycles", rcnt, 6);
      chk("nto_err", ecnt, 0);
      chk("nto_read", dmem_read_o, 1);
      dmem_done_i = 1; dmem_rd_data_i = 9;
      tick();
      dmem_done_i = 0;
      chk("nto_done", req0_done_o, 1);
      chk("nto_rd", req0_rd_data_o, 9);
    end
    tick();

    // completion landing on the exact limit cycle
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 44;
    tick();
    req0_valid_i = 0;
    for (int i = 1; i <= TO; i++) begin
      dmem_done_i = (i == TO); dmem_rd_data_i = 32'hABCD;
      tick();
    end
    dmem_done_i = 0;
    chk("edge_done", req0_done_o, 1);
    chk("edge_err", req0_err_o, 0);
    chk("edge_rd", req0_rd_data_o, 32'hABCD);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between two requesters: requester 0 is the load/store path's `dmem_read_write_unit`, and requester 1 is a secondary memory client (store-buffer drain or debug port). Grants are round-robin, and one transaction is outstanding at a time. The arbiter latches the winning request, drives the dmem strobes until `dmem_done_i`, then returns completion and read data to the owner. It sits between the memory-side units and the dmem model/controller.

## Interface
- `TIMEOUT_CYCLES`, 64: busy cycles allowed before abort (used only with the timeout feature); ≥1.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `reqN_valid_i` (N=0,1)  in  1  request pending.
- `reqN_write_i`  in  1  1 = store, 0 = load.
- `reqN_addr_i`  in  32 (`word32_t`)  effective address.
- `reqN_data_i`  in  32  store data.
- `reqN_ready_o`  out  1  grant; the request is accepted in a cycle where valid & ready.
- `reqN_done_o`  out  1  one-cycle completion pulse.
- `reqN_rd_data_o`  out  32  load data; valid with `done_o`, held until that requester's next load completion.
- `reqN_err_o`  out  1  abort flag, valid with `done_o`.
- `dmem_rd_data_i`  in  32  read data, valid with `dmem_done_i`.
- `dmem_done_i`  in  1  one-cycle completion from memory.
- `dmem_read_o`, `dmem_write_o`  out  1  level strobes.
- `dmem_addr_o`, `dmem_data_o`  out  32  latched address/data.

## Operation
- States: IDLE and BUSY. Round-robin pointer `prio_q` names the preferred requester.
- IDLE:
  - `reqN_ready_o` = `reqN_valid_i` & winner (combinational).
  - If only one requester is valid, it wins regardless of the pointer.
  - If both are valid, `prio_q` wins.
- On accept:
  - Latch write/addr/data/owner.
  - `prio_q` ← the other requester.
  - Go to BUSY.
- BUSY:
  - Exactly one of `dmem_read_o`/`dmem_write_o` is high (per the latched write bit).
  - `dmem_addr_o`/`dmem_data_o` hold the latched values.
  - All `ready_o` stay low; requester inputs are ignored.
- BUSY with `dmem_done_i`=1 → IDLE. In the next cycle:
  - Strobes are low.
  - Owner's `done_o`=1.
  - On a load, owner's `rd_data_o` ← `dmem_rd_data_i`; on a store, `rd_data_o` is unchanged.
- `dmem_done_i` is ignored in IDLE.
- `dmem_data_o` is don't-care on loads but still driven from the latch.
- Reset (asynchronous, any state) drives IDLE, `prio_q`=0, all strobes/`done_o`/`err_o`/`ready_o` 0, `rd_data_o`=0, latches 0. An in-flight transaction is dropped with no `done_o`.

## Timing
- Accept in cycle T → strobes high from T+1.
- `dmem_done_i` sampled high in cycle D (D ≥ T+1) → strobes low and `done_o` high in D+1.
- A new accept is allowed in D+1 (IDLE), with its strobes in D+2.
- Minimum valid→`done_o` latency: 2 cycles.
- Request to strobe is registered (no combinational path from `reqN_*_i` to `dmem_*_o`).
- `ready_o` is combinational from `valid_i` and state.
- Both valid in the same cycle: exactly one `ready_o`; the loser stays pending and wins the next IDLE arbitration.

## Configuration
- `DMEM_ARB_TIMEOUT_EN` defined:
  - A BUSY cycle counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on accept.
  - When it reaches `TIMEOUT_CYCLES` without `dmem_done_i`, the transaction aborts: next cycle strobes low, IDLE, owner `done_o`=1 and `err_o`=1, `rd_data_o` unchanged.
  - A `dmem_done_i` arriving in the same cycle as the limit wins; the completion is normal with no error.
  - A late `dmem_done_i` after an abort is ignored.
- Undefined: no counter; `reqN_err_o` tied 0; BUSY waits indefinitely. The port list is identical in both builds.

## Structure
- `data_types` package gains:
  - `dmem_req_t` struct {write, addr `word32_t`, data `word32_t`}.
  - `dmem_arb_state_e` enum {ARB_IDLE, ARB_BUSY}.
  - `DMEM_REQ_IDLE` constant (all zero).
- No sub-module: the pointer and timeout counter are small enough to stay inline.

## Test plan
- Req0 store addr 2 data 0, `dmem_done_i` 5 cycles after the strobe → `dmem_write_o` high 5 cycles, addr=2, `req0_done_o` pulse, `err_o`=0.
- Req0 load addr 2, done with rd_data 500 → `dmem_read_o` held until done; next cycle `req0_done_o`=1, `req0_rd_data_o`=500, held afterwards.
- Both valid after reset → req0 granted first, req1 granted in the cycle req0's `done_o` fires; with both continuously valid, grants alternate 0,1,0,1.
- Reset asserted mid-BUSY, then `dmem_done_i` pulsed → strobes drop immediately, no `done_o` on either port, IDLE.
- With `DMEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no done → abort on the 4th busy cycle, `done_o`+`err_o` pulse, a late done ignored. Without the macro, the same stimulus keeps the strobe high.
- Done on the exact timeout cycle → normal completion, `err_o`=0, rd_data captured.
